// File: rtl/pingpong_wr_ctrl_pkg.sv
// Shared definitions for the ping-pong result SRAM controllers.
// The write side and the read side both import this package, so strobe
// polarity, bank numbering and default geometry stay in one place.
package pingpong_wr_ctrl_pkg;

  // SRAM chip-select / write-enable strobes are active-low.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  // Bank index as carried on cur_bank.
  localparam logic BANK1 = 1'b0;
  localparam logic BANK2 = 1'b1;

  // Default geometry: one frame of 2048 32-bit words per bank.
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 2048;

  // Ownership state of one bank.
  //   FLAG_FREE    : the writer may fill this bank.
  //   FLAG_PENDING : the last word was just accepted and is being written;
  //                  the bank is closed to the writer but not yet announced.
  //   FLAG_FULL    : a complete frame is announced to the downstream layer.
  typedef enum logic [1:0] {
    FLAG_FREE    = 2'd0,
    FLAG_PENDING = 2'd1,
    FLAG_FULL    = 2'd2
  } flag_state_e;

endpackage

// File: rtl/pp_bank_flag.sv
// Ownership flags for one bank of the ping-pong SRAM.
// A bank is closed to the writer when its last word is accepted, announced
// as full one cycle later (after the last write strobe has been issued),
// and handed back when downstream pulses empty. An empty pulse for a bank
// that is not announced as full is a protocol violation and is reported as
// a single-cycle err_pulse; the bank state is left untouched in that case.
module pp_bank_flag
  import pingpong_wr_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_last,
  input  logic        empty,
  output logic        full,
  output logic        err_pulse,
  output flag_state_e state
);

  flag_state_e state_nxt;

  // State register; reset releases the bank to the writer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FLAG_FREE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: close on the last accepted word, announce one cycle later,
  // release on an empty pulse only once announced.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FLAG_FREE: begin
        if (set_last) begin
          state_nxt = FLAG_PENDING;
        end
      end
      FLAG_PENDING: begin
        state_nxt = FLAG_FULL;
      end
      FLAG_FULL: begin
        if (empty) begin
          state_nxt = FLAG_FREE;
        end
      end
      default: begin
        state_nxt = FLAG_FREE;
      end
    endcase
  end

  // Outputs: full level to downstream and the misuse pulse for sticky err.
  always_comb begin
    full      = (state == FLAG_FULL);
    err_pulse = empty && (state != FLAG_FULL);
  end

endmodule

// File: rtl/pingpong_wr_ctrl.sv
// Write-side sequencer for the two-bank ping-pong result SRAM.
// Result words from the compute datapath are written into the bank being
// filled at consecutive addresses. When a frame is complete the bank is
// announced full to the next layer and filling moves to the other bank.
// A bank is only refilled after downstream returns its empty pulse, so the
// datapath stalls instead of overwriting unread data.
module pingpong_wr_ctrl
  import pingpong_wr_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              bank_cs1_n,
  output logic              bank_we1_n,
  output logic              bank_cs2_n,
  output logic              bank_we2_n,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_data,
  input  logic              next_sram_empty1,
  input  logic              next_sram_empty2,
  output logic              next_sram_full1,
  output logic              next_sram_full2,
  output logic              cur_bank,
  output logic              err
);

  // Address of the final word of a frame.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] wr_cnt;
  logic              accept;
  logic              last_word;
  logic              set_last1;
  logic              set_last2;
  logic              err_pulse1;
  logic              err_pulse2;
  flag_state_e       flag_state1;
  flag_state_e       flag_state2;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  // in_ready depends on registered bank state only (never on in_valid), and
  // in_data must be stable while in_valid is high and in_ready is low.

  // Ready while the bank being filled is neither pending nor full.
  always_comb begin
    if (cur_bank == BANK1) begin
      in_ready = (flag_state1 == FLAG_FREE);
    end else begin
      in_ready = (flag_state2 == FLAG_FREE);
    end
  end

  // Accept decode and the close request for the bank receiving its last word.
  always_comb begin
    accept    = in_valid && in_ready;
    last_word = accept && (wr_cnt == LAST_ADDR);
    set_last1 = last_word && (cur_bank == BANK1);
    set_last2 = last_word && (cur_bank == BANK2);
  end

  // Write address counter: one step per accepted word, wraps at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (accept) begin
      if (last_word) begin
        wr_cnt <= '0;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // Bank toggle: the next word after a frame end goes to the other bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_bank <= BANK1;
    end else if (last_word) begin
      cur_bank <= ~cur_bank;
    end
  end

  // Registered strobes: one active-low cycle for the bank written, else idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_cs1_n <= STROBE_OFF;
      bank_we1_n <= STROBE_OFF;
      bank_cs2_n <= STROBE_OFF;
      bank_we2_n <= STROBE_OFF;
    end else begin
      bank_cs1_n <= (accept && (cur_bank == BANK1)) ? STROBE_ON : STROBE_OFF;
      bank_we1_n <= (accept && (cur_bank == BANK1)) ? STROBE_ON : STROBE_OFF;
      bank_cs2_n <= (accept && (cur_bank == BANK2)) ? STROBE_ON : STROBE_OFF;
      bank_we2_n <= (accept && (cur_bank == BANK2)) ? STROBE_ON : STROBE_OFF;
    end
  end

  // Registered write address and data; they hold between accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_addr <= '0;
      bank_data <= '0;
    end else if (accept) begin
      bank_addr <= wr_cnt;
      bank_data <= in_data;
    end
  end

  // Sticky error: any empty pulse for a bank that was not announced full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_pulse1 || err_pulse2) begin
      err <= 1'b1;
    end
  end

  pp_bank_flag u_flag1 (
    .clk       (clk),
    .rst       (rst),
    .set_last  (set_last1),
    .empty     (next_sram_empty1),
    .full      (next_sram_full1),
    .err_pulse (err_pulse1),
    .state     (flag_state1)
  );

  pp_bank_flag u_flag2 (
    .clk       (clk),
    .rst       (rst),
    .set_last  (set_last2),
    .empty     (next_sram_empty2),
    .full      (next_sram_full2),
    .err_pulse (err_pulse2),
    .state     (flag_state2)
  );

endmodule
